// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable word width, CPOL/CPHA modes, bit order,
// runtime SCLK divider, one-hot active-low selects and full-duplex capture.
module spi_master_multi #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_SS = 4,
  parameter int unsigned DIV_W  = 16,
  localparam int unsigned SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int unsigned CNT_W  = DIV_W + 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    h_q, h_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;

  logic [EDGE_W-1:0]   edge_nxt;
  logic                edge_odd;
  logic                last_edge;
  logic                half_end;
  logic                sample_edge;
  logic                shift_edge;
  logic [IDX_W-1:0]    bit_n;
  logic [IDX_W-1:0]    bit_idx;
  logic                first_bit;
  logic [NUM_SS-1:0]   sel_mask;

  // Edge bookkeeping, next-bit selection and chip-select decode
  always_comb begin
    edge_nxt    = edge_q + EDGE_W'(1);
    edge_odd    = edge_nxt[0];
    last_edge   = (edge_nxt == EDGE_W'(2 * DATA_W));
    half_end    = (cnt_q == CNT_W'(1));
    sample_edge = cpha_q ? !edge_odd : edge_odd;
    shift_edge  = cpha_q ? edge_odd : (!edge_odd && !last_edge);
    bit_n       = cpha_q ? IDX_W'(edge_q >> 1) : IDX_W'(edge_nxt >> 1);
    bit_idx     = lsb_q ? bit_n : (IDX_W'(DATA_W - 1) - bit_n);
    first_bit   = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    for (int i = 0; i < NUM_SS; i++) begin
      sel_mask[i] = (ss_sel != SS_W'(i));
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_d       = h_q;
    edge_d    = edge_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol_q;
        mosi_d = 1'b0;
        ss_n_d = '1;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_SETUP;
          h_d     = CNT_W'(clk_div) + CNT_W'(1);
          cnt_d   = CNT_W'(clk_div) + CNT_W'(1);
          edge_d  = '0;
          tx_d    = tx_data;
          rx_sh_d = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          sclk_d  = cpol;
          mosi_d  = cpha ? 1'b0 : first_bit;
          ss_n_d  = sel_mask;
          busy_d  = 1'b1;
        end
      end
      S_SETUP: begin
        if (half_end) begin
          state_d = S_XFER;
          cnt_d   = h_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_XFER: begin
        if (half_end) begin
          cnt_d  = h_q;
          edge_d = edge_nxt;
          sclk_d = !sclk_q;
          if (sample_edge) begin
            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
          end
          if (shift_edge) begin
            mosi_d = tx_q[bit_idx];
          end
          if (last_edge) begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (half_end) begin
          state_d   = S_IDLE;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      h_q       <= '0;
      edge_q    <= '0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      edge_q    <= edge_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule
